// File: rtl/serial_tx_if.sv
// Producer-side bundle for serial_tx.
//   data_in : word to send (WIDTH bits)
//   valid   : producer has a word on data_in
//   ready   : transmitter can accept a word
//   txd     : serial line, idle level 1
//   busy    : frame in progress
//   done    : one-cycle pulse when a frame's stop bit completes
// master = producer/observer side, slave = transmitter side.
interface serial_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             txd;
    logic             busy;
    logic             done;

    modport master (output data_in, valid, input ready, txd, busy, done);
    modport slave  (input data_in, valid, output ready, txd, busy, done);
endinterface

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, optional
// even parity bit, stop bit; each bit held CLKS_PER_BIT clocks on txd.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : serial_tx_if slave (data_in/valid in; ready/txd/busy/done out)
// All outputs are flops whose next values are decoded from the next state.
module serial_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               bit_end;

    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // ready is high throughout IDLE, so valid alone completes the handshake
                if (bus.valid) begin
                    shift_d = bus.data_in;
                    par_d   = ^bus.data_in;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        txd_d   = 1'b1;
        busy_d  = 1'b1;
        ready_d = 1'b0;
        done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
        unique case (state_d)
            S_IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d;
            S_STOP:   txd_d = 1'b1;
            default: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bus.txd   = txd_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (W=8/C=4/P=1 and W=4/C=1/P=0) checked
// against a frame model built from the framing rules (bit list, slot = t/C).
module tb_serial_tx;
    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_tx_if #(.WIDTH(8)) b1 ();
    serial_tx_if #(.WIDTH(4)) b2 ();

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cfg_w(input int which);
        return (which == 1) ? 8 : 4;
    endfunction
    function automatic int cfg_c(input int which);
        return (which == 1) ? 4 : 1;
    endfunction
    function automatic int cfg_p(input int which);
        return (which == 1) ? 1 : 0;
    endfunction

    task automatic drive(input int which, input logic [31:0] d, input logic v);
        if (which == 1) begin
            b1.data_in = d[7:0];
            b1.valid   = v;
        end else begin
            b2.data_in = d[3:0];
            b2.valid   = v;
        end
    endtask

    // {txd, busy, ready, done}
    function automatic logic [3:0] outs(input int which);
        if (which == 1) return {b1.txd, b1.busy, b1.ready, b1.done};
        return {b2.txd, b2.busy, b2.ready, b2.done};
    endfunction

    // Send word d and check every cycle of the frame against the model.
    // keep=1 holds valid high with data_in=nxt after acceptance.
    task automatic frame(input int which, input logic [31:0] d, input bit keep,
                         input logic [31:0] nxt, input string tag);
        int         w, c, p, len, ones;
        bit         bits[$];
        logic [3:0] o, e;
        w = cfg_w(which);
        c = cfg_c(which);
        p = cfg_p(which);
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < w; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p != 0) bits.push_back((ones % 2) == 1);
        bits.push_back(1'b1);
        len = bits.size() * c;
        o = outs(which);
        chk({tag, " ready-before"}, 32'(o[1]), 32'd1);
        drive(which, d, 1'b1);
        tick();
        if (keep) drive(which, nxt, 1'b1);
        else      drive(which, $urandom, 1'b0);
        for (int t = 0; t <= len; t++) begin
            o = outs(which);
            e = (t < len) ? {bits[t / c], 3'b100} : 4'b1011;
            chk($sformatf("%s t=%0d", tag, t), 32'(o), 32'(e));
            if (t < len) tick();
        end
    endtask

    task automatic gap(input int which, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(which, $urandom, 1'b0);
            tick();
            chk($sformatf("%s gap%0d", tag, i), 32'(outs(which)), 32'(4'b1010));
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  o;
        reset = 1'b1;
        drive(1, 0, 1'b0);
        drive(2, 0, 1'b0);
        #1;
        chk("reset dut1", 32'(outs(1)), 32'(4'b1010));
        chk("reset dut2", 32'(outs(2)), 32'(4'b1010));
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle dut1 c%0d", i), 32'(outs(1)), 32'(4'b1010));
            chk($sformatf("idle dut2 c%0d", i), 32'(outs(2)), 32'(4'b1010));
        end

        frame(1, 32'hA5, 1'b0, 0, "a5");
        gap(1, 2, "a5");

        frame(1, 32'h01, 1'b1, 32'h7F, "b2b-first");
        frame(1, 32'h7F, 1'b0, 0, "b2b-second");
        gap(1, 1, "b2b");

        frame(1, 32'h3C, 1'b1, 32'hFF, "iso");
        frame(1, 32'hFF, 1'b0, 0, "iso-next");
        gap(1, 1, "iso");

        // Reset asserted between clock edges during data bit 3.
        d = 32'($urandom_range(0, 255));
        drive(1, d, 1'b1);
        tick();
        drive(1, $urandom, 1'b0);
        repeat (17) tick();
        o = outs(1);
        chk("rst bit3 txd", 32'(o[3]), 32'(d[3]));
        #2;
        reset = 1'b1;
        #1;
        chk("rst async", 32'(outs(1)), 32'(4'b1010));
        tick();
        chk("rst held", 32'(outs(1)), 32'(4'b1010));
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk($sformatf("rst no-done c%0d", i), 32'(outs(1)), 32'(4'b1010));
        end
        frame(1, 32'h55, 1'b0, 0, "post-rst");
        gap(1, 1, "post-rst");

        frame(2, 32'hB, 1'b0, 0, "w4-b");
        gap(2, 1, "w4-b");

        for (int n = 0; n < 6; n++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                frame(1, d, 1'b1, d ^ 32'h5A, $sformatf("rnd1-%0d", n));
                frame(1, d ^ 32'h5A, 1'b0, 0, $sformatf("rnd1b-%0d", n));
            end else begin
                frame(1, d, 1'b0, 0, $sformatf("rnd1-%0d", n));
            end
            gap(1, $urandom_range(0, 3), $sformatf("rnd1-%0d", n));
        end
        for (int n = 0; n < 12; n++) begin
            d = $urandom;
            frame(2, d, 1'b1, ~d, $sformatf("rnd2-%0d", n));
            frame(2, ~d, 1'b0, 0, $sformatf("rnd2b-%0d", n));
            gap(2, $urandom_range(0, 2), $sformatf("rnd2-%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
